// File: rtl/qwi_led_pwm_ctrl_if.sv
// Configuration write port of the multi-channel LED PWM driver.
// Latency: n/a (signal bundle only).
// Backpressure: none; a write is a single-cycle strobe that is always accepted or dropped.
interface qwi_led_pwm_ctrl_if #(
  parameter int CH_AW   = 4,
  parameter int PWM_W   = 8,
  parameter int BLINK_W = 16
);
  logic               cfg_wr;
  logic [CH_AW-1:0]   cfg_ch;
  logic [1:0]         cfg_mode;
  logic [PWM_W-1:0]   cfg_duty;
  logic [BLINK_W-1:0] cfg_blink;

  modport master (output cfg_wr, cfg_ch, cfg_mode, cfg_duty, cfg_blink);
  modport slave  (input  cfg_wr, cfg_ch, cfg_mode, cfg_duty, cfg_blink);
endinterface

// File: rtl/qwi_led_pwm_ctrl.sv
// Multi-channel LED driver: off/on/blink(/breathe) per channel over a shared PWM timebase.
// Latency: mode/state change reaches led_o one clk later (registered); duty applies from next frame.
// Backpressure: none; out-of-range channel writes are dropped. Optional breathe mode: QWI_LED_BREATHE_EN.
module qwi_led_pwm_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int PWM_W    = 8,
  parameter int PRESCALE = 100,
  parameter int BLINK_W  = 16,
  parameter int CH_AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  qwi_led_pwm_ctrl_if.slave cfg,
  output logic              frame_start,
  output logic [NUM_CH-1:0] led_o
);

  localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  // Last PWM count is 2^PWM_W-2 so that an all-ones duty is always on.
  localparam logic [PWM_W-1:0] PWM_LAST = {{(PWM_W-1){1'b1}}, 1'b0};
  localparam logic [CH_AW:0]   NUM_CH_V = (CH_AW+1)'(NUM_CH);

  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE} mode_e;

  logic [PS_W-1:0]    presc_q, presc_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic               frame_start_q, frame_start_d;
  logic               tick, frame_evt, wr_ok;

  mode_e              mode_q [NUM_CH];
  mode_e              mode_d [NUM_CH];
  logic [PWM_W-1:0]   shadow_q [NUM_CH];
  logic [PWM_W-1:0]   shadow_d [NUM_CH];
  logic [PWM_W-1:0]   active_q [NUM_CH];
  logic [PWM_W-1:0]   active_d [NUM_CH];
  logic [BLINK_W-1:0] blink_per_q [NUM_CH];
  logic [BLINK_W-1:0] blink_per_d [NUM_CH];
  logic [BLINK_W-1:0] bcnt_q [NUM_CH];
  logic [BLINK_W-1:0] bcnt_d [NUM_CH];
  logic [NUM_CH-1:0]  phase_q, phase_d;
  logic [NUM_CH-1:0]  led_q, led_d;
`ifdef QWI_LED_BREATHE_EN
  logic [PWM_W-1:0]   bduty_q [NUM_CH];
  logic [PWM_W-1:0]   bduty_d [NUM_CH];
  logic [NUM_CH-1:0]  dir_dn_q, dir_dn_d;
`endif

  // Shared timebase: prescaler tick, PWM counter and frame boundary event.
  always_comb begin
    tick          = (presc_q == PS_LAST);
    presc_d       = tick ? '0 : presc_q + 1'b1;
    frame_evt     = tick && (pwm_cnt_q == PWM_LAST);
    pwm_cnt_d     = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = frame_evt ? '0 : pwm_cnt_q + 1'b1;
    end
    frame_start_d = frame_evt;
    wr_ok         = cfg.cfg_wr && ({1'b0, cfg.cfg_ch} < NUM_CH_V);
  end

  // Timebase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Per-channel config capture, frame-synchronous duty/blink/breathe update and LED decode.
  always_comb begin
    phase_d = phase_q;
    led_d   = '0;
`ifdef QWI_LED_BREATHE_EN
    dir_dn_d = dir_dn_q;
`endif
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mode_d[ch]      = mode_q[ch];
      shadow_d[ch]    = shadow_q[ch];
      active_d[ch]    = active_q[ch];
      blink_per_d[ch] = blink_per_q[ch];
      bcnt_d[ch]      = bcnt_q[ch];
`ifdef QWI_LED_BREATHE_EN
      bduty_d[ch]     = bduty_q[ch];
`endif
      if (frame_evt) begin
        // Loading from the registered shadow means a same-clk write lands a frame later.
        active_d[ch] = shadow_q[ch];
        if (mode_q[ch] == MODE_BLINK && blink_per_q[ch] != '0) begin
          if (bcnt_q[ch] == blink_per_q[ch] - 1'b1) begin
            phase_d[ch] = ~phase_q[ch];
            bcnt_d[ch]  = '0;
          end else begin
            bcnt_d[ch]  = bcnt_q[ch] + 1'b1;
          end
        end
`ifdef QWI_LED_BREATHE_EN
        if (mode_q[ch] == MODE_BREATHE) begin
          if (shadow_q[ch] == '0) begin
            bduty_d[ch]  = '0;
            dir_dn_d[ch] = 1'b0;
          end else if (!dir_dn_q[ch]) begin
            if (bduty_q[ch] >= shadow_q[ch]) begin
              // Shadow was lowered below the current level: start descending.
              bduty_d[ch]  = bduty_q[ch] - 1'b1;
              dir_dn_d[ch] = 1'b1;
            end else begin
              bduty_d[ch]  = bduty_q[ch] + 1'b1;
              dir_dn_d[ch] = (bduty_q[ch] + 1'b1 == shadow_q[ch]);
            end
          end else if (bduty_q[ch] == '0) begin
            bduty_d[ch]  = PWM_W'(1);
            dir_dn_d[ch] = 1'b0;
          end else begin
            bduty_d[ch]  = bduty_q[ch] - 1'b1;
            dir_dn_d[ch] = (bduty_q[ch] != PWM_W'(1));
          end
        end
`endif
      end
      if (wr_ok && cfg.cfg_ch == CH_AW'(ch)) begin
        mode_d[ch]      = mode_e'(cfg.cfg_mode);
        shadow_d[ch]    = cfg.cfg_duty;
        blink_per_d[ch] = cfg.cfg_blink;
        bcnt_d[ch]      = '0;
        phase_d[ch]     = 1'b1;
`ifdef QWI_LED_BREATHE_EN
        bduty_d[ch]     = '0;
        dir_dn_d[ch]    = 1'b0;
`endif
      end
      case (mode_q[ch])
        MODE_ON:    led_d[ch] = (pwm_cnt_q < active_q[ch]);
        MODE_BLINK: led_d[ch] = phase_q[ch] && (pwm_cnt_q < active_q[ch]);
`ifdef QWI_LED_BREATHE_EN
        MODE_BREATHE: led_d[ch] = (pwm_cnt_q < bduty_q[ch]);
`else
        MODE_BREATHE: led_d[ch] = 1'b0;
`endif
        default:    led_d[ch] = 1'b0;
      endcase
    end
  end

  // Per-channel state and registered LED outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '1;
      led_q   <= '0;
`ifdef QWI_LED_BREATHE_EN
      dir_dn_q <= '0;
`endif
      for (int ch = 0; ch < NUM_CH; ch++) begin
        mode_q[ch]      <= MODE_OFF;
        shadow_q[ch]    <= '0;
        active_q[ch]    <= '0;
        blink_per_q[ch] <= '0;
        bcnt_q[ch]      <= '0;
`ifdef QWI_LED_BREATHE_EN
        bduty_q[ch]     <= '0;
`endif
      end
    end else begin
      phase_q <= phase_d;
      led_q   <= led_d;
`ifdef QWI_LED_BREATHE_EN
      dir_dn_q <= dir_dn_d;
`endif
      for (int ch = 0; ch < NUM_CH; ch++) begin
        mode_q[ch]      <= mode_d[ch];
        shadow_q[ch]    <= shadow_d[ch];
        active_q[ch]    <= active_d[ch];
        blink_per_q[ch] <= blink_per_d[ch];
        bcnt_q[ch]      <= bcnt_d[ch];
`ifdef QWI_LED_BREATHE_EN
        bduty_q[ch]     <= bduty_d[ch];
`endif
      end
    end
  end

  assign frame_start = frame_start_q;
  assign led_o       = led_q;

endmodule

// File: tb/tb_qwi_led_pwm_ctrl.sv
// Directed testbench for qwi_led_pwm_ctrl (NUM_CH=4, PWM_W=4, PRESCALE=2: 30-clk frames).
// Waveforms are captured per frame as 30-sample vectors aligned to frame_start.
// Expected patterns: duty d in on/blink mode -> first 2*d samples of the frame high.
module tb_qwi_led_pwm_ctrl;
  localparam int NUM_CH   = 4;
  localparam int PWM_W    = 4;
  localparam int PRESCALE = 2;
  localparam int BLINK_W  = 16;
  localparam int CH_AW    = 4;
  localparam int FRAME    = 30;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic [NUM_CH-1:0] led_o;

  int checks = 0;
  int errors = 0;
  logic [FRAME-1:0] wave [NUM_CH];

  qwi_led_pwm_ctrl_if #(.CH_AW(CH_AW), .PWM_W(PWM_W), .BLINK_W(BLINK_W)) cfg_if ();

  qwi_led_pwm_ctrl #(
    .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESCALE(PRESCALE), .BLINK_W(BLINK_W), .CH_AW(CH_AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_if.slave),
    .frame_start (frame_start),
    .led_o       (led_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME-1:0] pat(input int d);
    logic [FRAME-1:0] one;
    one = 1;
    if (d >= 15) return '1;
    return (one << (2 * d)) - one;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int mode, input int duty, input int blink);
    cfg_if.cfg_wr    = 1'b1;
    cfg_if.cfg_ch    = CH_AW'(ch);
    cfg_if.cfg_mode  = 2'(mode);
    cfg_if.cfg_duty  = PWM_W'(duty);
    cfg_if.cfg_blink = BLINK_W'(blink);
    step();
    cfg_if.cfg_wr    = 1'b0;
  endtask

  // Wait for a frame_start sample, then record the following 30 samples of every channel.
  task automatic capture_frame(input string tag);
    int   guard;
    logic fs_extra;
    guard    = 0;
    fs_extra = 1'b0;
    while (frame_start !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    check({tag, "_fs_found"}, 32'(frame_start), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      step();
      for (int ch = 0; ch < NUM_CH; ch++) wave[ch][i] = led_o[ch];
      if (i < FRAME - 1) fs_extra = fs_extra | frame_start;
    end
    check({tag, "_fs_gap"}, 32'(fs_extra), 32'd0);
    check({tag, "_fs_period"}, 32'(frame_start), 32'd1);
  endtask

  // Capture one frame and compare each channel against its duty pattern (-1 skips a channel).
  task automatic check_frame(input string tag, input int d0, input int d1, input int d2, input int d3);
    int d [NUM_CH];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    capture_frame(tag);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (d[ch] >= 0) check($sformatf("%s_ch%0d", tag, ch), 32'(wave[ch]), 32'(pat(d[ch])));
    end
  endtask

  // From reset release: frame_start first pulses on the 30th clk and every channel stays dark.
  task automatic post_reset_check(input string tag);
    logic              fs_acc;
    logic [NUM_CH-1:0] led_acc;
    fs_acc  = 1'b0;
    led_acc = '0;
    for (int i = 1; i < FRAME; i++) begin
      step();
      fs_acc  = fs_acc | frame_start;
      led_acc = led_acc | led_o;
    end
    check({tag, "_fs_early"}, 32'(fs_acc), 32'd0);
    check({tag, "_led_dark"}, 32'(led_acc), 32'd0);
    step();
    check({tag, "_fs_first"}, 32'(frame_start), 32'd1);
    check_frame({tag, "_frame"}, 0, 0, 0, 0);
  endtask

  int bl [8] = '{15, 15, 0, 0, 0, 15, 15, 15};
`ifdef QWI_LED_BREATHE_EN
  int br [7] = '{1, 2, 3, 2, 1, 0, 1};
`endif

  initial begin
    int lows;
    int guard;
    rst_n            = 1'b0;
    cfg_if.cfg_wr    = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_mode  = '0;
    cfg_if.cfg_duty  = '0;
    cfg_if.cfg_blink = '0;

    // Reset state.
    #1;
    check("rst_led", 32'(led_o), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    repeat (3) step();
    check("rst_led_held", 32'(led_o), 32'd0);
    rst_n = 1'b1;
    post_reset_check("init");

    // ch1 on, duty 5: 10 clks high per frame from the next frame.
    repeat (5) step();
    wr(1, 1, 5, 0);
    check_frame("on5", 0, 5, 0, 0);

    // ch0 solid on, then duty 0 mid-frame: stays high to frame end, then dark.
    repeat (5) step();
    wr(0, 1, 15, 0);
    check_frame("on15", 15, 5, 0, 0);
    repeat (7) step();
    wr(0, 1, 0, 0);
    lows  = 0;
    guard = 0;
    while (frame_start !== 1'b1 && guard < 40) begin
      if (led_o[0] !== 1'b1) lows++;
      step();
      guard++;
    end
    check("duty_hold_lows", 32'(lows), 32'd0);
    check_frame("duty0", 0, 5, 0, 0);

    // ch2 blink, half-period 3 frames.
    repeat (4) step();
    wr(2, 2, 15, 3);
    for (int i = 0; i < 8; i++) check_frame($sformatf("blink%0d", i), 0, 5, bl[i], 0);

    // Out-of-range channel writes are dropped (ch2 has just toggled dark).
    repeat (3) step();
    wr(7, 1, 15, 1);
    wr(4, 1, 15, 1);
    check_frame("bad_ch", 0, 5, 0, 0);

    // ch3 mode 3: breathe when enabled, dark otherwise.
    repeat (2) step();
    wr(3, 3, 3, 0);
`ifdef QWI_LED_BREATHE_EN
    for (int i = 0; i < 7; i++) check_frame($sformatf("breathe%0d", i), -1, 5, -1, br[i]);
`else
    check_frame("mode3_a", -1, 5, -1, 0);
    check_frame("mode3_b", -1, 5, -1, 0);
`endif

    // Mid-frame mode change on ch1 takes effect on the next clk (plus output register).
    step();
    wr(1, 0, 5, 0);
    check("mode_off_lag", 32'(led_o[1]), 32'd1);
    step();
    check("mode_off_now", 32'(led_o[1]), 32'd0);
    wr(1, 1, 5, 0);
    step();
    check("mode_on_again", 32'(led_o[1]), 32'd1);

    // Asynchronous reset mid-operation.
    rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led_o), 32'd0);
    check("arst_fs", 32'(frame_start), 32'd0);
    repeat (3) step();
    check("arst_led_held", 32'(led_o), 32'd0);
    rst_n = 1'b1;
    post_reset_check("rerst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qwi_led_pwm_ctrl.md
Name: qwi_led_pwm_ctrl

Overview:
- Parametrised multi-channel LED driver in PL logic. Replaces the single PS-GPIO-driven LED with NUM_CH channels.
- Each channel has its own mode: off, on, blink, or breathe. Brightness is set by a shared-timebase PWM duty.
- Configured through a simple one-cycle write strobe from the PS-side register block. Drives board LED pins directly.

Parameters:
- NUM_CH, 4, number of LED channels (1..16)
- PWM_W, 8, PWM counter/duty width in bits
- PRESCALE, 100, clk cycles per PWM tick (>=1)
- BLINK_W, 16, width of the per-channel blink half-period in PWM frames
- CH_AW, 4, channel address width (2^CH_AW >= NUM_CH)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_wr  in  1  single-cycle write strobe
- cfg_ch  in  CH_AW  target channel index
- cfg_mode  in  2  0=off, 1=on, 2=blink, 3=breathe
- cfg_duty  in  PWM_W  brightness duty (max = always on)
- cfg_blink  in  BLINK_W  blink half-period in PWM frames
- frame_start  out  1  one-clk pulse at each PWM frame start
- led_o  out  NUM_CH  LED drive, active-high, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low rst_n.
- Reset state:
  - led_o=0, frame_start=0.
  - All counters=0; all modes=off; all duties and blink values=0.
  - Blink phase=1; breathe direction=up.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick is asserted when it equals PRESCALE-1, then it wraps to 0.
- PWM counter:
  - Advances on tick through 0..2^PWM_W-2, then wraps to 0.
  - A frame is therefore 2^PWM_W-1 ticks.
  - frame_start pulses one clk, on the clk where tick wraps the counter to 0.
- pwm_on(ch) = (pwm_cnt < active_duty(ch)). duty=0 means never on; duty=all-ones means always on.
- Config write (cfg_wr=1):
  - If cfg_ch >= NUM_CH, the write is ignored and no state changes.
  - Mode is updated from the next clk. The same write clears the blink counter, sets phase=1, and sets breathe duty=0, direction=up.
  - Duty goes to a shadow register. active_duty loads from the shadow on frame_start, so there are no mid-frame glitches.
  - Blink period is updated immediately.
- Write and frame_start on the same clk: active_duty loads the old shadow value. The new duty applies from the following frame.
- Modes, with led_o registered (1 clk latency from internal state):
  - off: led_o(ch)=0.
  - on: led_o(ch)=pwm_on.
  - blink: per-channel frame counter.
    - On frame_start, if the counter equals cfg_blink-1, phase toggles and the counter clears; otherwise the counter increments.
    - cfg_blink=0 means no toggle; phase stays 1.
    - led_o = phase & pwm_on.
  - breathe: only with the optional feature (see below).
- Mode change mid-frame: takes effect next clk. The PWM counter is shared and never reset by writes.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Release is synchronous to clk.

Optional Feature:
- Macro: QWI_LED_BREATHE_EN.
- Defined:
  - Mode 3 is breathe. On each frame_start the channel's active duty steps by 1.
  - Direction up: step up until it reaches the shadow duty, then flip to down.
  - Direction down: step down until it reaches 0, then flip to up.
  - If the shadow duty is 0, the channel stays at 0.
  - led_o = pwm_on using the stepped duty.
- Not defined:
  - Mode 3 behaves as off (led_o=0).
  - Breathe counters and direction registers are not synthesised.

Test Plan:
- Reset with PRESCALE=2, PWM_W=4, no writes -> led_o=0 throughout; frame_start pulses every 30 clks (15 ticks x 2).
- Write ch1 mode=on, duty=5 -> from the next frame_start, led_o[1] is high for 5 ticks (10 clks) and low for 10 ticks per frame; other channels stay 0.
- Write ch0 mode=on, duty=15; then duty=0 mid-frame -> led_o[0] stays solid high until the next frame_start, then goes solid low.
- Write ch2 mode=blink, duty=15, blink=3 -> led_o[2] is high for 3 frames (90 clks), low for 3 frames, repeating.
- Write with cfg_ch=7 (NUM_CH=4), and separately assert rst_n low mid-blink -> the write is ignored with no output change; on reset, led_o=0 immediately and all channels are off after release.
- With QWI_LED_BREATHE_EN, write ch3 mode=3, duty=3 -> active duty steps 0,1,2,3,2,1,0,1... across frames. Without the macro -> led_o[3]=0.
